// File: rtl/ps2_key_event_queue.sv
// PS/2 key event queue: turns decoder make/break strobes into PRESS/RELEASE/LONG events buffered in a FWFT FIFO.
// Defining PS2_KEY_REPEAT_EVT_EN additionally emits REPEAT events for typematic makes.
module ps2_key_event_queue #(
  parameter int         NUM_KEYS    = 2,
  parameter logic [8:0] KEY_CODE0   = 9'h069,
  parameter logic [8:0] KEY_CODE1   = 9'h072,
  parameter logic [8:0] KEY_CODE2   = 9'h05A,
  parameter logic [8:0] KEY_CODE3   = 9'h029,
  parameter int         FIFO_DEPTH  = 4,
  parameter int         LONG_CYCLES = 50000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                key_valid,
  input  logic [8:0]          last_change,
  input  logic                key_make,
  input  logic                evt_ready,
  input  logic                clr_ovf,
  output logic                evt_valid,
  output logic [3:0]          evt_data,
  output logic [NUM_KEYS-1:0] held,
  output logic                ovf,
  output logic [7:0]          drop_cnt
);

  localparam int CNT_W  = $clog2(LONG_CYCLES);
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int FILL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0]    CNT_REACH_PRE = CNT_W'(LONG_CYCLES - 2);
  localparam logic [CNT_W-1:0]    CNT_ONE       = CNT_W'(1'b1);
  localparam logic [FILL_W-1:0]   FILL_FULL     = FILL_W'(FIFO_DEPTH);
  localparam logic [NUM_KEYS-1:0] KEY_ONE       = NUM_KEYS'(1'b1);

  localparam logic [1:0] EVT_PRESS   = 2'b00;
  localparam logic [1:0] EVT_RELEASE = 2'b01;
  localparam logic [1:0] EVT_LONG    = 2'b10;
  localparam logic [1:0] EVT_REPEAT  = 2'b11;

`ifdef PS2_KEY_REPEAT_EVT_EN
  localparam logic REPEAT_EN = 1'b1;
`else
  localparam logic REPEAT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_UP        = 2'b00,
    ST_DOWN      = 2'b01,
    ST_LONG_DONE = 2'b10
  } key_state_t;

  function automatic logic [8:0] key_code(input logic [1:0] idx);
    case (idx)
      2'd0:    key_code = KEY_CODE0;
      2'd1:    key_code = KEY_CODE1;
      2'd2:    key_code = KEY_CODE2;
      2'd3:    key_code = KEY_CODE3;
      default: key_code = 9'h000;
    endcase
  endfunction

  key_state_t          state_r [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_r   [NUM_KEYS];
  logic [NUM_KEYS-1:0] long_pend_r;
  logic [NUM_KEYS-1:0] held_r;

  logic [3:0]          mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [FILL_W-1:0]   fill_r;
  logic                evt_valid_r;
  logic [3:0]          evt_data_r;
  logic                ovf_r;
  logic [7:0]          drop_cnt_r;

  logic [NUM_KEYS-1:0] match_s;
  logic [NUM_KEYS-1:0] key_hit_s;
  logic                dec_push_s;
  logic [1:0]          dec_type_s;
  logic [1:0]          dec_idx_s;
  logic                long_any_s;
  logic                long_take_s;
  logic [1:0]          long_idx_s;
  logic                push_s;
  logic [3:0]          push_data_s;
  logic                pop_s;
  logic                full_s;
  logic                wr_en_s;
  logic                drop_s;
  logic [PTR_W-1:0]    rd_nxt_s;
  logic [FILL_W-1:0]   fill_nxt_s;
  logic [3:0]          head_nxt_s;

  // Match the decoder code against the watched keys; the lowest index wins on duplicates.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      match_s[i] = key_valid && (last_change == key_code(2'(i)));
    end
    key_hit_s = match_s & (~match_s + KEY_ONE);
  end

  // Classify the decoder strobe for the matched key into an event to push.
  always_comb begin
    dec_push_s = 1'b0;
    dec_type_s = EVT_PRESS;
    dec_idx_s  = 2'b00;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (key_hit_s[i]) begin
        dec_idx_s = 2'(i);
        case (state_r[i])
          ST_UP: begin
            dec_push_s = key_make;
            dec_type_s = EVT_PRESS;
          end
          ST_DOWN, ST_LONG_DONE: begin
            dec_push_s = key_make ? REPEAT_EN : 1'b1;
            dec_type_s = key_make ? EVT_REPEAT : EVT_RELEASE;
          end
          default: begin
            dec_push_s = 1'b0;
            dec_type_s = EVT_PRESS;
          end
        endcase
      end else begin
        dec_push_s = dec_push_s;
        dec_type_s = dec_type_s;
        dec_idx_s  = dec_idx_s;
      end
    end
  end

  // Push arbitration: decoder events first, otherwise the lowest pending LONG.
  always_comb begin
    long_any_s = |long_pend_r;
    long_idx_s = 2'b00;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      long_idx_s = long_pend_r[i] ? 2'(i) : long_idx_s;
    end
    long_take_s = long_any_s && !dec_push_s;
    push_s      = dec_push_s || long_any_s;
    push_data_s = dec_push_s ? {dec_type_s, dec_idx_s} : {EVT_LONG, long_idx_s};
  end

  // FIFO control; a pop frees the slot for a same-cycle push even when full.
  always_comb begin
    pop_s      = evt_valid_r && evt_ready;
    full_s     = (fill_r == FILL_FULL);
    wr_en_s    = push_s && (!full_s || pop_s);
    drop_s     = push_s && full_s && !pop_s;
    rd_nxt_s   = rd_ptr_r + PTR_W'(pop_s);
    fill_nxt_s = fill_r + FILL_W'(wr_en_s) - FILL_W'(pop_s);
    head_nxt_s = (wr_en_s && (wr_ptr_r == rd_nxt_s)) ? push_data_s : mem_r[rd_nxt_s];
  end

  // Per-key UP/DOWN/LONG_DONE state, hold counters and pending LONG flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        state_r[i] <= ST_UP;
        cnt_r[i]   <= '0;
      end
      long_pend_r <= '0;
      held_r      <= '0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) begin
        case (state_r[i])
          ST_UP: begin
            if (key_hit_s[i] && key_make) begin
              state_r[i] <= ST_DOWN;
              cnt_r[i]   <= '0;
              held_r[i]  <= 1'b1;
            end else begin
              state_r[i] <= ST_UP;
            end
          end
          ST_DOWN: begin
            if (key_hit_s[i] && !key_make) begin
              state_r[i] <= ST_UP;
              held_r[i]  <= 1'b0;
            end else if (cnt_r[i] == CNT_REACH_PRE) begin
              // Counter lands on LONG_CYCLES-1 at this edge.
              state_r[i]     <= ST_LONG_DONE;
              cnt_r[i]       <= cnt_r[i] + CNT_ONE;
              long_pend_r[i] <= 1'b1;
            end else begin
              cnt_r[i] <= cnt_r[i] + CNT_ONE;
            end
          end
          ST_LONG_DONE: begin
            if (key_hit_s[i] && !key_make) begin
              state_r[i]     <= ST_UP;
              held_r[i]      <= 1'b0;
              long_pend_r[i] <= 1'b0;
            end else if (long_take_s && (long_idx_s == 2'(i))) begin
              long_pend_r[i] <= 1'b0;
            end else begin
              state_r[i] <= ST_LONG_DONE;
            end
          end
          default: begin
            state_r[i]     <= ST_UP;
            held_r[i]      <= 1'b0;
            long_pend_r[i] <= 1'b0;
          end
        endcase
      end
    end
  end

  // FIFO storage, pointers and the registered head (evt_data holds while empty).
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= 4'h0;
      end
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      fill_r      <= '0;
      evt_valid_r <= 1'b0;
      evt_data_r  <= 4'h0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= push_data_s;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      rd_ptr_r    <= rd_nxt_s;
      fill_r      <= fill_nxt_s;
      evt_valid_r <= (fill_nxt_s != '0);
      if (fill_nxt_s != '0) begin
        evt_data_r <= head_nxt_s;
      end else begin
        evt_data_r <= evt_data_r;
      end
    end
  end

  // Overflow flag and saturating drop counter; a same-cycle drop beats clr_ovf.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'h00;
    end else if (drop_s) begin
      ovf_r <= 1'b1;
      if (clr_ovf) begin
        drop_cnt_r <= 8'h01;
      end else if (drop_cnt_r != 8'hFF) begin
        drop_cnt_r <= drop_cnt_r + 8'h01;
      end else begin
        drop_cnt_r <= drop_cnt_r;
      end
    end else if (clr_ovf) begin
      ovf_r      <= 1'b0;
      drop_cnt_r <= 8'h00;
    end else begin
      ovf_r      <= ovf_r;
      drop_cnt_r <= drop_cnt_r;
    end
  end

  assign evt_valid = evt_valid_r;
  assign evt_data  = evt_data_r;
  assign held      = held_r;
  assign ovf       = ovf_r;
  assign drop_cnt  = drop_cnt_r;

endmodule

// File: doc/ps2_key_event_queue.md
Name: ps2_key_event_queue

Overview:
- Sits between the PS/2 keyboard decoder and the stopwatch/speed controller.
- Converts the decoder's raw outputs (key_valid pulse, 9-bit last_change, key_down bit) into clean per-key events for up to 4 watched keys: press, release and long-press.
- Filters typematic repeats.
- Buffers events in a small FIFO with a valid/ready handshake, so the controller consumes one event per accepted transfer instead of polling key_down.

Parameters:
- NUM_KEYS, 2, number of watched keys, legal range 1..4.
- KEY_CODE0, 9'h069, code for key index 0 ({extend, make code}).
- KEY_CODE1, 9'h072, code for key index 1.
- KEY_CODE2, 9'h05A, code for key index 2.
- KEY_CODE3, 9'h029, code for key index 3.
- FIFO_DEPTH, 4, event FIFO entries; power of two, 2..16.
- LONG_CYCLES, 50000000, clk cycles a key must stay held before a LONG event is generated; at least 2.

Ports:
- clk, input, 1, system clock, 100 MHz.
- rst, input, 1, synchronous active-high reset.
- key_valid, input, 1, one-cycle pulse from the decoder; last_change and key_make are valid in the same cycle.
- last_change, input, 9, {extend, code} of the latest scan code.
- key_make, input, 1, key_down[last_change] in the key_valid cycle; 1 = make, 0 = break.
- evt_ready, input, 1, consumer accepts the head event when this and evt_valid are both high.
- clr_ovf, input, 1, clears ovf and drop_cnt.
- evt_valid, output, 1, FIFO not empty.
- evt_data, output, 4, {type[1:0], idx[1:0]}. Type: 00 PRESS, 01 RELEASE, 10 LONG, 11 REPEAT.
- held, output, NUM_KEYS, level: key i is currently held.
- ovf, output, 1, sticky flag: an event was dropped because the FIFO was full.
- drop_cnt, output, 8, number of dropped events, saturates at 255.

Behaviour:
- Reset (synchronous):
  - evt_valid=0, evt_data=0, held=0, ovf=0, drop_cnt=0.
  - FIFO emptied; all hold counters and long_sent flags cleared.
  - A break arriving after reset for a key that was held before reset is ignored.
- Matching: a key_valid cycle matches index i if last_change==KEY_CODEi and i<NUM_KEYS. Lowest index wins on duplicate codes. Non-matching codes are ignored.
- Per-key state machine, states UP / DOWN / LONG_DONE:
  - UP, make → DOWN; counter=0; push PRESS.
  - DOWN, make → stay in DOWN; typematic repeat dropped, counter not reset.
  - DOWN, break → UP; push RELEASE.
  - DOWN, counter reaches LONG_CYCLES-1 → LONG_DONE; raise long_pend[i].
  - LONG_DONE, make → stay in LONG_DONE; repeat dropped.
  - LONG_DONE, break → UP; push RELEASE.
  - UP, break → ignored.
  - Counter increments each cycle in DOWN and holds in the other states.
- held[i] = 1 in DOWN or LONG_DONE.
- Push arbitration (at most one push per cycle):
  - A decoder-derived event (PRESS, RELEASE or REPEAT) has priority.
  - Otherwise the lowest-index set long_pend bit pushes LONG and clears that bit.
  - A long_pend bit that has not been pushed when its key releases is cancelled. The RELEASE is pushed and no LONG follows.
- FIFO:
  - First-word-fall-through; evt_data is the head entry.
  - Latency: key_valid in cycle N → evt_valid=1 with the event in cycle N+1 (if the FIFO was empty).
  - Push and pop in the same cycle are both performed, even when full.
  - Push while full without a pop: the event is discarded, ovf is set, drop_cnt increments (saturating at 255).
  - Pop while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- clr_ovf: clears ovf and drop_cnt next cycle. If a drop occurs in the same cycle, the drop wins: ovf=1, drop_cnt=1.
- evt_data keeps its last value while evt_valid=0; the consumer must ignore it.

Optional Feature:
- Macro: PS2_KEY_REPEAT_EVT_EN.
- When defined: a make received in DOWN or LONG_DONE pushes REPEAT (type 11) for that key. It has the same priority as other decoder events and counts toward overflow.
- When undefined: repeats are silently dropped, as described above; type 11 is never produced.

Test Plan:
- Press and release: make 9'h069, evt_ready=1. Expect evt_data=4'b0000 in the next cycle, held=2'b01. Then break 9'h069. Expect evt_data=4'b0100, held=2'b00.
- Typematic: make 9'h072, then 5 more makes of 9'h072, then a break, with LONG_CYCLES=16. Expect exactly 2 events: 4'b0001 then 4'b0101; no LONG, since the key is held for fewer than 16 cycles. With the macro defined, expect 5 × 4'b1101 between them.
- Long press: LONG_CYCLES=16, make 9'h069 held for 40 cycles. Expect PRESS, then 4'b1000 sixteen cycles after the PRESS push, then a single RELEASE after the break; no second LONG.
- Overflow: FIFO_DEPTH=4, evt_ready=0, alternate make/break of 9'h069 six times (6 events). Expect 4 entries stored, ovf=1, drop_cnt=2. Pulse clr_ovf. Expect ovf=0, drop_cnt=0, and the 4 stored events pop in order PRESS, RELEASE, PRESS, RELEASE.
- Collision: with LONG_CYCLES=16, key 0's counter reaches LONG_CYCLES-1 in the same cycle key_valid brings a make for key 1. Expect PRESS idx1 pushed first, then LONG idx0 one cycle later.
- Reset mid-hold: hold key 0, assert rst for 1 cycle. Expect all outputs 0. A following break of 9'h069 produces no event.
